spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

Command stage directly downstream of the SPI slave. It consumes each 24-bit frame the slave presents on its read handshake and decodes the opcode byte. Write opcodes update local registers; read opcodes load a 16-bit reply into the slave's write buffer, which the slave shifts out during the next SPI frame. It owns the LED register and the inverted-data scratch register visible to the host.

## Interface
Parameters:
- LED_RESET, 16'h0000, value of `leds` after reset
- ERR_SAT, 8'hFF, saturation value of `err_count`

Ports:
- clk  in  1  system clock; the single clock for the block
- reset  in  1  asynchronous, active-high reset
- rd_data_available  in  1  slave holds a received frame
- rd_data  in  24  frame from slave; [7:0] opcode, [23:8] payload
- rd_ack  out  1  one-cycle frame acknowledge to slave
- wr_buffer_free  in  1  slave write buffer empty
- wr_en  out  1  one-cycle reply load strobe to slave
- wr_data  out  16  reply word
- leds  out  16  LED register
- err_count  out  8  count of unknown opcodes, saturating
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Opcodes:
  - 0x00: NOP.
  - 0x01: INIT. Treated as NOP here; the slave consumes the first INIT itself.
  - 0x02: WR_INV. `scratch <= payload`.
  - 0x03: RD_INV. Reply `~scratch`.
  - 0x04: WR_LED. `leds <= payload`.
  - 0x05: RD_LED. Reply `leds`.
  - 0x06–0xFF: `err_count` increments by 1, saturating at ERR_SAT. No other effect.
- States and transitions:
  - IDLE → ACK when `rd_data_available`=1. Latch `rd_data` into `frame`; register `rd_ack`<=1.
  - ACK → EXEC unconditionally. `rd_ack`<=0. This extra cycle guarantees the slave has dropped `rd_data_available` before IDLE samples it again.
  - EXEC, write/NOP/unknown opcode: apply the register update; go to IDLE.
  - EXEC, read opcode: capture the reply value into `wr_data`; go to REPLY.
  - REPLY: wait while `wr_buffer_free`=0. When it is 1, `wr_en`<=1 and go to DONE.
  - DONE: `wr_en`<=0; go to IDLE.
- Back-pressure: while in REPLY, no new frame is acknowledged. The slave holds `rd_data_available` and stops receiving until then.
- The reply value is sampled in EXEC, not in REPLY. A read is therefore unaffected by later state, since no further write can occur before the reply is sent.
- The host must leave at least 8 clk cycles between frames for a reply to appear in the following frame. A shorter gap is not an error; the reply is simply sent one frame later.

## Timing
- Reset values:
  - `rd_ack`=0, `wr_en`=0, `wr_data`=0
  - `leds`=LED_RESET, `scratch`=0, `err_count`=0
  - `busy`=0, state=IDLE
- Reset asserted mid-transaction: all of the above take effect immediately, and any pending reply is dropped. The slave's own state is not touched.
- Cycle numbering from the first clk edge `e0` at which `rd_data_available`=1 is seen in IDLE:
  - `rd_ack` high during e0→e1.
  - Write effects visible after e2.
  - `wr_en` high during e3→e4 when `wr_buffer_free` is already 1.
- Latencies:
  - Minimum frame-to-frame acceptance: 3 cycles for write opcodes, 5 cycles for read opcodes.
  - `wr_en` and `rd_ack` are never high for more than one cycle.
  - `wr_en` is never asserted while `wr_buffer_free`=0.
- `err_count` at ERR_SAT plus a further unknown opcode: stays at ERR_SAT.

## Structure
- Package `spi_cmd_pkg` holds:
  - opcode constants: OP_NOP, OP_INIT, OP_WR_INV, OP_RD_INV, OP_WR_LED, OP_RD_LED
  - the 3-bit state encoding: IDLE, ACK, EXEC, REPLY, DONE
  - frame field widths: OPCODE_W=8, PAYLOAD_W=16
- The package is shared with the top level and the testbench host model.
- Single flat module; no sub-module warranted.

## Test plan
- Frame 0x1234_04 (payload 0x1234, opcode 0x04), then frame 0x0000_05 → `leds`=0x1234 after e2 of the first frame; second frame gives one `wr_en` pulse with `wr_data`=0x1234.
- Frame 0xA5A5_02, then frame 0x0000_03 → `wr_data`=0x5A5A. Read straight after reset → `wr_data`=0xFFFF.
- Frame 0x0000_03 with `wr_buffer_free` held 0 for 20 cycles → `busy` stays 1 and `rd_ack` does not fire for a queued second frame. `wr_en` fires exactly 1 cycle after free rises; the second frame is then acknowledged.
- 300 frames with opcode 0x7F → `err_count`=0xFF; `leds` and `scratch` unchanged.
- Reset asserted while in REPLY → `wr_en`=0 and `busy`=0 immediately; no reply is issued after reset releases.
- `rd_data_available` held high continuously with frames 0x0001_04, 0x0002_04 → exactly one `rd_ack` per frame, spaced ≥3 cycles apart; `leds` ends at 0x0002.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: frame layout, opcodes and FSM encoding.
package spi_cmd_pkg;

    localparam int OPCODE_W  = 8;
    localparam int PAYLOAD_W = 16;
    localparam int FRAME_W   = OPCODE_W + PAYLOAD_W;

    localparam logic [OPCODE_W-1:0] OP_NOP    = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_INIT   = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_WR_INV = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_RD_INV = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_WR_LED = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_RD_LED = 8'h05;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd1,
        EXEC  = 3'd2,
        REPLY = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [OPCODE_W-1:0] frame_opcode(input logic [FRAME_W-1:0] f);
        return f[OPCODE_W-1:0];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] frame_payload(input logic [FRAME_W-1:0] f);
        return f[FRAME_W-1:OPCODE_W];
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Frame/reply handshake between the SPI slave (master modport) and the command decoder (slave modport).
interface spi_cmd_decoder_if;

    logic                                rd_data_available;
    logic [spi_cmd_pkg::FRAME_W-1:0]     rd_data;
    logic                                rd_ack;
    logic                                wr_buffer_free;
    logic                                wr_en;
    logic [spi_cmd_pkg::PAYLOAD_W-1:0]   wr_data;

    modport master (
        output rd_data_available, rd_data, wr_buffer_free,
        input  rd_ack, wr_en, wr_data
    );

    modport slave (
        input  rd_data_available, rd_data, wr_buffer_free,
        output rd_ack, wr_en, wr_data
    );

endinterface

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI frames: writes update LED/scratch registers, reads load a 16-bit reply
// into the slave's write buffer, unknown opcodes bump a saturating error counter.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter logic [PAYLOAD_W-1:0] LED_RESET = 16'h0000,
    parameter logic [7:0]           ERR_SAT   = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_cmd_decoder_if.slave     bus,
    output logic [PAYLOAD_W-1:0] leds,
    output logic [7:0]           err_count,
    output logic                 busy
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= ERR_SAT) ? ERR_SAT : v + 8'd1;
    endfunction

    state_t               state, state_nxt;
    logic [FRAME_W-1:0]   frame;
    logic                 frame_ld;
    logic                 rd_ack, rd_ack_nxt;
    logic                 wr_en, wr_en_nxt;
    logic [PAYLOAD_W-1:0] wr_data, wr_data_nxt;
    logic [PAYLOAD_W-1:0] leds_nxt;
    logic [PAYLOAD_W-1:0] scratch, scratch_nxt;
    logic [7:0]           err_nxt;
    logic [OPCODE_W-1:0]  opcode;
    logic [PAYLOAD_W-1:0] payload;

    assign opcode  = frame_opcode(frame);
    assign payload = frame_payload(frame);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_ack    <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            leds      <= LED_RESET;
            scratch   <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            rd_ack    <= rd_ack_nxt;
            wr_en     <= wr_en_nxt;
            wr_data   <= wr_data_nxt;
            leds      <= leds_nxt;
            scratch   <= scratch_nxt;
            err_count <= err_nxt;
        end
    end

    // The frame holding register is pure data and is only consumed after a load.
    always_ff @(posedge clk) begin
        if (frame_ld) frame <= bus.rd_data;
    end

    always_comb begin
        state_nxt   = state;
        frame_ld    = 1'b0;
        rd_ack_nxt  = 1'b0;
        wr_en_nxt   = 1'b0;
        wr_data_nxt = wr_data;
        leds_nxt    = leds;
        scratch_nxt = scratch;
        err_nxt     = err_count;
        case (state)
            IDLE: begin
                if (bus.rd_data_available) begin
                    state_nxt  = ACK;
                    rd_ack_nxt = 1'b1;
                    frame_ld   = 1'b1;
                end
            end
            // Spare cycle so the slave has dropped rd_data_available before IDLE looks again.
            ACK: state_nxt = EXEC;
            EXEC: begin
                state_nxt = IDLE;
                case (opcode)
                    OP_NOP, OP_INIT: ;
                    OP_WR_INV: scratch_nxt = payload;
                    OP_RD_INV: begin
                        wr_data_nxt = ~scratch;
                        state_nxt   = REPLY;
                    end
                    OP_WR_LED: leds_nxt = payload;
                    OP_RD_LED: begin
                        wr_data_nxt = leds;
                        state_nxt   = REPLY;
                    end
                    default: err_nxt = sat_inc(err_count);
                endcase
            end
            REPLY: begin
                if (bus.wr_buffer_free) begin
                    wr_en_nxt = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rd_ack  = rd_ack;
    assign bus.wr_en   = wr_en;
    assign bus.wr_data = wr_data;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: table-driven frames with a reply scoreboard plus hand-written corner cases.
module tb_spi_cmd_decoder;
    import spi_cmd_pkg::*;

    localparam logic [15:0] LED_RST = 16'hC3C3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] leds;
    logic [7:0]  err_count;
    logic        busy;

    spi_cmd_decoder_if bus();

    spi_cmd_decoder #(.LED_RESET(LED_RST), .ERR_SAT(8'hFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .leds      (leds),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_wr   = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [23:0] frame;
        logic        has_reply;
        logic [15:0] reply;
        logic [15:0] leds;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic wait_ack(output int cycles);
        bit ok = 0;
        cycles = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.rd_ack === 1'b1) ok = 1;
        end
        if (!ok) timeout("rd_ack");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1;
        end
        if (!ok) timeout("busy_clear");
    endtask

    task automatic send_frame(input logic [23:0] f);
        int cyc;
        bus.rd_data_available = 1'b1;
        bus.rd_data           = f;
        wait_ack(cyc);
        bus.rd_data_available = 1'b0;
        wait_idle();
    endtask

    task automatic expect_reply(input logic [15:0] v);
        exp_q.push_back(v);
        n_push++;
    endtask

    // Reply monitor: every wr_en pulse pops one expected word; pulses must be single-cycle.
    initial begin
        logic prev_wr_en = 1'b0;
        logic prev_rd_ack = 1'b0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_wr_en  = 1'b0;
                prev_rd_ack = 1'b0;
            end else begin
                if (bus.wr_en === 1'b1) begin
                    n_wr++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL wr_en_unexpected: got reply %h, expected none", bus.wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_data", {16'h0, bus.wr_data}, {16'h0, e});
                    end
                    check("wr_en_single", {31'h0, prev_wr_en}, 32'h0);
                end
                if (bus.rd_ack === 1'b1) check("rd_ack_single", {31'h0, prev_rd_ack}, 32'h0);
                prev_wr_en  = bus.wr_en;
                prev_rd_ack = bus.rd_ack;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int wr_before;

        vecs[0]  = '{24'h000003, 1'b1, 16'hFFFF, 16'hC3C3, 8'h00};
        vecs[1]  = '{24'h000005, 1'b1, 16'hC3C3, 16'hC3C3, 8'h00};
        vecs[2]  = '{24'h123404, 1'b0, 16'h0000, 16'h1234, 8'h00};
        vecs[3]  = '{24'h000005, 1'b1, 16'h1234, 16'h1234, 8'h00};
        vecs[4]  = '{24'hA5A502, 1'b0, 16'h0000, 16'h1234, 8'h00};
        vecs[5]  = '{24'h000003, 1'b1, 16'h5A5A, 16'h1234, 8'h00};
        vecs[6]  = '{24'h000000, 1'b0, 16'h0000, 16'h1234, 8'h00};
        vecs[7]  = '{24'h000001, 1'b0, 16'h0000, 16'h1234, 8'h00};
        vecs[8]  = '{24'h000006, 1'b0, 16'h0000, 16'h1234, 8'h01};
        vecs[9]  = '{24'hBEEFFF, 1'b0, 16'h0000, 16'h1234, 8'h02};
        vecs[10] = '{24'h000005, 1'b1, 16'h1234, 16'h1234, 8'h02};

        reset                 = 1'b1;
        bus.rd_data_available = 1'b0;
        bus.rd_data           = '0;
        bus.wr_buffer_free    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rd_ack", {31'h0, bus.rd_ack}, 32'h0);
        check("rst_wr_en", {31'h0, bus.wr_en}, 32'h0);
        check("rst_wr_data", {16'h0, bus.wr_data}, 32'h0);
        check("rst_leds", {16'h0, leds}, {16'h0, LED_RST});
        check("rst_err", {24'h0, err_count}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // Write effects must be visible right after e2: ack seen after e0, leds checked after e2.
        bus.rd_data_available = 1'b1;
        bus.rd_data           = 24'h777704;
        wait_ack(cyc);
        bus.rd_data_available = 1'b0;
        @(negedge clk);
        check("leds_before_e2", {16'h0, leds}, {16'h0, LED_RST});
        @(negedge clk);
        check("leds_after_e2", {16'h0, leds}, 32'h7777);
        check("busy_after_write", {31'h0, busy}, 32'h0);
        send_frame({LED_RST, OP_WR_LED});

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].has_reply) expect_reply(vecs[i].reply);
            send_frame(vecs[i].frame);
            check($sformatf("vec%0d_leds", i), {16'h0, leds}, {16'h0, vecs[i].leds});
            check($sformatf("vec%0d_err", i), {24'h0, err_count}, {24'h0, vecs[i].err});
        end

        // Back-pressure: reply stalls in REPLY, a queued second frame is not acknowledged.
        bus.wr_buffer_free = 1'b0;
        expect_reply(16'h5A5A);
        bus.rd_data_available = 1'b1;
        bus.rd_data           = 24'h000003;
        wait_ack(cyc);
        bus.rd_data = 24'h000904;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_busy", {31'h0, busy}, 32'h1);
            check("bp_no_ack", {31'h0, bus.rd_ack}, 32'h0);
            check("bp_no_wr_en", {31'h0, bus.wr_en}, 32'h0);
        end
        bus.wr_buffer_free = 1'b1;
        @(negedge clk);
        check("bp_wr_en_after_free", {31'h0, bus.wr_en}, 32'h1);
        wait_ack(cyc);
        bus.rd_data_available = 1'b0;
        wait_idle();
        check("bp_second_frame_leds", {16'h0, leds}, 32'h0009);

        // Saturation of the unknown-opcode counter.
        for (int i = 0; i < 300; i++) send_frame(24'h00007F);
        check("sat_err", {24'h0, err_count}, 32'hFF);
        check("sat_leds", {16'h0, leds}, 32'h0009);
        expect_reply(16'h5A5A);
        send_frame(24'h000003);
        check("sat_err_hold", {24'h0, err_count}, 32'hFF);

        // Reset while a reply is pending: it must be dropped.
        bus.wr_buffer_free    = 1'b0;
        bus.rd_data_available = 1'b1;
        bus.rd_data           = 24'h000005;
        wait_ack(cyc);
        bus.rd_data_available = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        wr_before = n_wr;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_wr_en", {31'h0, bus.wr_en}, 32'h0);
        check("mid_rst_wr_data", {16'h0, bus.wr_data}, 32'h0);
        check("mid_rst_leds", {16'h0, leds}, {16'h0, LED_RST});
        check("mid_rst_err", {24'h0, err_count}, 32'h0);
        @(negedge clk);
        reset              = 1'b0;
        bus.wr_buffer_free = 1'b1;
        repeat (10) @(negedge clk);
        check("no_reply_after_rst", n_wr, wr_before);
        check("post_rst_busy", {31'h0, busy}, 32'h0);

        // rd_data_available held high across two back-to-back write frames.
        bus.rd_data_available = 1'b1;
        bus.rd_data           = 24'h000104;
        wait_ack(cyc);
        bus.rd_data = 24'h000204;
        wait_ack(cyc);
        check("ack_spacing_ge3", {31'h0, (cyc >= 3)}, 32'h1);
        bus.rd_data_available = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_extra_ack", {31'h0, bus.rd_ack}, 32'h0);
        end
        wait_idle();
        check("cont_leds", {16'h0, leds}, 32'h0002);

        check("queue_drained", exp_q.size(), 0);
        check("reply_count", n_wr, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
